// File: rtl/joybus_multi_host.sv
// Round-robin JOYBUS poller: shares one tx/rx engine pair across NUM_CH ports, tracks
// per-channel connection and holds the latest controller word. Optional JOYBUS_PROBE_EN probes disconnected ports.
module joybus_multi_host #(
  parameter int NUM_CH              = 4,
  parameter int POLL_CYCLES         = 1250000,
  parameter int RESP_TIMEOUT_CYCLES = 2500,
  parameter int MISS_LIMIT          = 3
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       en,
  input  logic                                       poll_now,
  output logic [$clog2(NUM_CH > 1 ? NUM_CH : 2)-1:0] ch_sel,
  output logic                                       cmd_rdy,
  output logic [7:0]                                 cmd_data,
  output logic [5:0]                                 rsp_bits,
  input  logic                                       tx_done,
  input  logic                                       rx_done,
  input  logic [31:0]                                rx_data,
  output logic [NUM_CH*32-1:0]                       cntlr_data,
  output logic [NUM_CH-1:0]                          cntlr_upd,
  output logic [NUM_CH-1:0]                          connected,
  output logic                                       round_done
);

  localparam int CW = $clog2(NUM_CH > 1 ? NUM_CH : 2);
  localparam int PW = $clog2(POLL_CYCLES > 1 ? POLL_CYCLES : 2);
  localparam int TW = $clog2(RESP_TIMEOUT_CYCLES > 1 ? RESP_TIMEOUT_CYCLES : 2);
  localparam int MW = $clog2(MISS_LIMIT + 1);

  localparam logic [CW-1:0] LAST_CH   = CW'(NUM_CH - 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
  localparam logic [TW-1:0] RESP_LAST = TW'(RESP_TIMEOUT_CYCLES - 1);
  localparam logic [MW-1:0] MISS_MAX  = MW'(MISS_LIMIT);
  localparam logic [MW-1:0] MISS_EDGE = MW'(MISS_LIMIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_TX,
    WAIT_RX,
    NEXT
  } state_t;

  state_t         state, state_next;
  logic [PW-1:0]  ivl;
  logic [TW-1:0]  tcnt;
  logic           timeout;
  logic [31:0]    slot [NUM_CH];
  logic [MW-1:0]  miss [NUM_CH];

  assign timeout = (tcnt == RESP_LAST);

`ifdef JOYBUS_PROBE_EN
  // A disconnected port gets a status probe instead of a full poll.
  logic probe;
  assign probe = !connected[ch_sel];
`endif

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) cntlr_data[i*32 +: 32] = slot[i];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    cmd_rdy    = 1'b0;
    cmd_data   = 8'h00;
    rsp_bits   = 6'd0;
    round_done = 1'b0;
    case (state)
      IDLE: begin
        if (en && (ivl == POLL_LAST || poll_now)) state_next = SEND;
      end
      SEND: begin
        cmd_rdy  = 1'b1;
`ifdef JOYBUS_PROBE_EN
        cmd_data = probe ? 8'h00 : 8'h01;
        rsp_bits = probe ? 6'd24 : 6'd32;
`else
        cmd_data = 8'h01;
        rsp_bits = 6'd32;
`endif
        state_next = WAIT_TX;
      end
      WAIT_TX: begin
        if (tx_done) state_next = WAIT_RX;
      end
      WAIT_RX: begin
        if (rx_done || timeout) state_next = NEXT;
      end
      NEXT: begin
        if (ch_sel == LAST_CH) begin
          round_done = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = SEND;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ivl       <= '0;
      tcnt      <= '0;
      ch_sel    <= '0;
      cntlr_upd <= '0;
      connected <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        slot[i] <= '0;
        miss[i] <= '0;
      end
    end else begin
      cntlr_upd <= '0;

      // Interval counter only runs while idling with polling enabled.
      if (state == IDLE && en && state_next == IDLE) ivl <= ivl + 1'b1;
      else                                           ivl <= '0;

      if (state == WAIT_RX) tcnt <= tcnt + 1'b1;
      else                  tcnt <= '0;

      if (state == NEXT) begin
        if (ch_sel == LAST_CH) ch_sel <= '0;
        else                   ch_sel <= ch_sel + 1'b1;
      end

      if (state == WAIT_RX) begin
        // A response arriving on the timeout cycle still counts.
        if (rx_done) begin
          miss[ch_sel]      <= '0;
          connected[ch_sel] <= 1'b1;
`ifdef JOYBUS_PROBE_EN
          if (!probe) begin
            slot[ch_sel]      <= rx_data;
            cntlr_upd[ch_sel] <= 1'b1;
          end
`else
          slot[ch_sel]      <= rx_data;
          cntlr_upd[ch_sel] <= 1'b1;
`endif
        end else if (timeout) begin
          if (miss[ch_sel] != MISS_MAX) miss[ch_sel] <= miss[ch_sel] + 1'b1;
          if (miss[ch_sel] >= MISS_EDGE) begin
            connected[ch_sel] <= 1'b0;
            slot[ch_sel]      <= '0;
          end
        end
      end
    end
  end

endmodule

// File: doc/joybus_multi_host.md
Name: joybus_multi_host

Overview:
- Parametrised successor to the single-port JOYBUS host.
- Polls NUM_CH controller ports round-robin every poll interval through one shared JOYBUS tx/rx engine pair, selected by ch_sel.
- Tracks per-channel connection state, with a response timeout and a miss counter.
- Holds the latest 32-bit controller word per channel and pulses a per-channel update strobe for the UART/debug consumers.

Parameters:
- NUM_CH, 4: number of controller ports, 1..8.
- POLL_CYCLES, 1250000: clk cycles between poll rounds (50 ms at 40 ns clk).
- RESP_TIMEOUT_CYCLES, 2500: cycles after tx_done with no rx_done before a miss is declared (100 us).
- MISS_LIMIT, 3: consecutive misses before a channel is marked disconnected.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  polling enable; 0 holds the FSM in IDLE with the interval counter cleared.
- poll_now  in  1  single-cycle pulse that starts a round immediately from IDLE.
- ch_sel  out  $clog2(NUM_CH) (min 1)  channel routed to the shared engine and the JB tristate mux.
- cmd_rdy  out  1  one-cycle command strobe to the tx engine.
- cmd_data  out  8  command byte.
- rsp_bits  out  6  expected response length for the rx engine.
- tx_done  in  1  tx engine finished.
- rx_done  in  1  rx engine captured a response.
- rx_data  in  32  response word, valid when rx_done is high.
- cntlr_data  out  NUM_CH*32  held controller words; channel i occupies [32i+31:32i].
- cntlr_upd  out  NUM_CH  one-cycle pulse per channel when its word is loaded.
- connected  out  NUM_CH  per-channel connected flag.
- round_done  out  1  one-cycle pulse after the last channel of a round completes.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE, ch_sel 0.
  - All miss counters 0, all connected 0, cntlr_data 0.
- States: IDLE, SEND, WAIT_TX, WAIT_RX, NEXT.
- IDLE:
  - Increments the interval counter while en is high.
  - Enters SEND with ch_sel=0 when the counter reaches POLL_CYCLES-1 or poll_now is high.
  - The counter clears on entering SEND.
  - poll_now outside IDLE is ignored.
- SEND:
  - Asserts cmd_rdy for exactly one cycle with cmd_data=8'h01 and rsp_bits=32.
  - Goes to WAIT_TX.
- WAIT_TX: waits for tx_done, then clears the timeout counter and goes to WAIT_RX.
- WAIT_RX:
  - On rx_done: load rx_data into slot ch_sel, pulse cntlr_upd[ch_sel] on the following cycle, clear the miss counter, set connected[ch_sel]=1, go to NEXT.
  - On timeout (counter == RESP_TIMEOUT_CYCLES-1) without rx_done: miss counter increments, saturating at MISS_LIMIT. When it reaches MISS_LIMIT, connected[ch_sel]=0 and the slot is cleared to 0. Go to NEXT.
  - rx_done and timeout in the same cycle: rx_done wins.
- NEXT:
  - If ch_sel == NUM_CH-1: pulse round_done, set ch_sel=0, go to IDLE.
  - Otherwise: ch_sel+1, go to SEND.
- ch_sel is stable from SEND through NEXT and changes only in NEXT.
- Data of a channel is never altered except by its own rx_done or by its disconnect clear.
- en deasserted mid-round: the current round completes, then the FSM stays in IDLE.
- rst mid-round: next clk returns everything to reset values; the pending rx_done is discarded.
- A stray tx_done or rx_done outside WAIT_TX/WAIT_RX is ignored.
- Single-channel latency: rx_done -> slot valid plus cntlr_upd, 1 cycle.

Optional Feature:
- Macro: JOYBUS_PROBE_EN.
- When defined, SEND for a disconnected channel issues status command 8'h00 with rsp_bits=24.
  - rx_done on a probe sets connected=1 and clears the miss counter, but does not load cntlr_data or pulse cntlr_upd.
  - Connected channels still get 8'h01/32.
- When undefined, every SEND issues 8'h01/32 regardless of connected, and the probe logic is not compiled.

Test Plan:
- Reset, en=1, POLL_CYCLES=100, NUM_CH=4, engine model answers with 32'hA5000000+ch -> first cmd_rdy at cycle 100 after en. Channels 0..3 load A5000000..A5000003, cntlr_upd pulses in order, connected=4'hF, round_done once.
- Channel 2 model silent, MISS_LIMIT=3 -> rounds 1-2 keep the old word and connected[2]=1. Round 3: connected[2]=0 and slot 2 = 0. Other channels unaffected.
- rx_done and timeout asserted in the same cycle on channel 1 -> data loaded, miss counter 0, connected[1]=1.
- poll_now pulse at interval count 10 -> SEND next cycle, counter cleared. A second poll_now during WAIT_RX causes no extra round.
- rst asserted during WAIT_RX of channel 1, rx_done in the same cycle -> all outputs 0, slot 1 not updated, state IDLE.
- With JOYBUS_PROBE_EN, channel 0 disconnected -> cmd_data=8'h00, rsp_bits=24. rx_done sets connected[0]=1 with no cntlr_upd[0]. The next round sends 8'h01.
